// File: rtl/msrv32_fetch_flush_ctrl_if.sv
// Control bundle between the msrv32 fetch/flush sequencer and the
// instruction memory, PC, IF/ID register and instruction mux it steers.
// Signal suffixes are from the sequencer's point of view.
interface msrv32_fetch_flush_ctrl_if;
    logic       instr_ack_in;
    logic       branch_taken_in;
    logic       trap_taken_in;
    logic       load_use_hazard_in;
    logic       instr_req_out;
    logic       pc_en_out;
    logic       if_id_en_out;
    logic       ibuf_load_out;
    logic       ibuf_sel_out;
    logic       flush_out;
    logic       fetch_timeout_out;
    logic [2:0] state_out;

    // Sequencer side
    modport master (
        input  instr_ack_in, branch_taken_in, trap_taken_in, load_use_hazard_in,
        output instr_req_out, pc_en_out, if_id_en_out, ibuf_load_out,
               ibuf_sel_out, flush_out, fetch_timeout_out, state_out
    );

    // Pipeline / memory side
    modport slave (
        output instr_ack_in, branch_taken_in, trap_taken_in, load_use_hazard_in,
        input  instr_req_out, pc_en_out, if_id_en_out, ibuf_load_out,
               ibuf_sel_out, flush_out, fetch_timeout_out, state_out
    );
endinterface

// File: rtl/msrv32_fetch_flush_ctrl.sv
// Fetch/decode front-end sequencer for msrv32: memory handshake, PC and
// IF/ID enables, redirect flush bubbles, load-use stalls with a one-entry
// hold buffer, and dropping of a fetch that was in flight at a redirect.
module msrv32_fetch_flush_ctrl #(
    parameter int FLUSH_CYCLES = 2,   // 1..7, includes the redirect cycle
    parameter int RESET_WAIT   = 1,   // 1..7
    parameter int MAX_WAIT     = 15   // 1..255
) (
    input  logic                             ms_riscv32_mp_clk_in,
    input  logic                             ms_riscv32_mp_rst_n_in,
    msrv32_fetch_flush_ctrl_if.master        bus
);
    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_FETCH    = 3'd1,
        S_WAIT_MEM = 3'd2,
        S_STALL    = 3'd3,
        S_FLUSH    = 3'd4
    } state_t;

    localparam logic [2:0] RESET_CNT  = 3'(RESET_WAIT - 1);
    localparam logic [2:0] FLUSH_CNT  = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);
    localparam state_t     REDIR_NEXT = (FLUSH_CYCLES == 1) ? S_FETCH : S_FLUSH;

    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;            // shared by INIT hold-off and FLUSH bubble
    logic [7:0] wait_cnt, wait_cnt_n;  // saturating memory-wait counter
    logic       discard, discard_n;    // next ack belongs to a pre-redirect fetch
    logic       buffered, buffered_n;  // hold buffer carries an uncaptured instruction
    logic       timeout, timeout_n;

    logic redirect;
    assign redirect = bus.branch_taken_in | bus.trap_taken_in;

    // State, counter and flag registers
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state    <= S_INIT;
            cnt      <= RESET_CNT;
            wait_cnt <= 8'd0;
            discard  <= 1'b0;
            buffered <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the same pre-edge values.
            state    <= state_n;
            cnt      <= cnt_n;
            wait_cnt <= wait_cnt_n;
            discard  <= discard_n;
            buffered <= buffered_n;
            timeout  <= timeout_n;
        end
    end

    // Next-state and combinational enables; priority redirect > hazard > ack
    always_comb begin
        // NOTE: every output defaults first so no path through the case infers a latch.
        state_n            = state;
        cnt_n              = cnt;
        wait_cnt_n         = wait_cnt;
        discard_n          = discard;
        buffered_n         = buffered;
        timeout_n          = timeout;
        bus.instr_req_out  = 1'b0;
        bus.pc_en_out      = 1'b0;
        bus.if_id_en_out   = 1'b0;
        bus.ibuf_load_out  = 1'b0;
        bus.ibuf_sel_out   = 1'b0;
        bus.flush_out      = 1'b0;

        if (state == S_INIT) begin
            bus.flush_out = 1'b1;
            if (cnt == 3'd0) state_n = S_FETCH;
            else             cnt_n   = cnt - 3'd1;
        end else if (redirect) begin
            // PC loads the target; whatever is in flight from WAIT_MEM is stale
            bus.flush_out = 1'b1;
            bus.pc_en_out = 1'b1;
            if (state == S_WAIT_MEM) discard_n = 1'b1;
            buffered_n = 1'b0;
            cnt_n      = FLUSH_CNT;
            state_n    = REDIR_NEXT;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (bus.load_use_hazard_in) begin
                        state_n = S_STALL;
                    end else begin
                        bus.instr_req_out = 1'b1;
                        if (bus.instr_ack_in) begin
                            if (discard) begin
                                discard_n = 1'b0;
                            end else begin
                                bus.pc_en_out    = 1'b1;
                                bus.if_id_en_out = 1'b1;
                            end
                        end else begin
                            state_n    = S_WAIT_MEM;
                            wait_cnt_n = 8'd1;
                        end
                    end
                end
                S_WAIT_MEM: begin
                    bus.instr_req_out = 1'b1;
                    if (bus.instr_ack_in) begin
                        if (discard) begin
                            discard_n = 1'b0;
                            state_n   = bus.load_use_hazard_in ? S_STALL : S_FETCH;
                        end else if (bus.load_use_hazard_in) begin
                            // Decode cannot take it yet: park it in the hold buffer
                            bus.ibuf_load_out = 1'b1;
                            bus.pc_en_out     = 1'b1;
                            buffered_n        = 1'b1;
                            state_n           = S_STALL;
                        end else begin
                            bus.pc_en_out    = 1'b1;
                            bus.if_id_en_out = 1'b1;
                            state_n          = S_FETCH;
                        end
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt_n = wait_cnt + 8'd1;
                    end
                end
                S_STALL: begin
                    if (!bus.load_use_hazard_in) begin
                        if (buffered) begin
                            bus.if_id_en_out = 1'b1;
                            bus.ibuf_sel_out = 1'b1;
                            buffered_n       = 1'b0;
                        end
                        state_n = S_FETCH;
                    end
                end
                S_FLUSH: begin
                    bus.flush_out = 1'b1;
                    if (bus.instr_ack_in) discard_n = 1'b0;
                    if (cnt == 3'd0) state_n = S_FETCH;
                    else             cnt_n   = cnt - 3'd1;
                end
                default: state_n = S_INIT;
            endcase
        end

        // Timeout latches on the edge that brings the wait count to the limit
        if (state_n == S_WAIT_MEM && wait_cnt_n >= WAIT_LIMIT) timeout_n = 1'b1;
    end

    assign bus.fetch_timeout_out = timeout;
    assign bus.state_out         = state;
endmodule
